core_job_sequencer: RTL

Consumer end of the core input interface: latches a mining job (midstate `HashState` plus the three fixed words w1..w3 of the header's second chunk) when the writer presents it. It then streams fully padded 512-bit second-chunk message blocks, one per nonce, to the SHA-256 round pipeline over a valid/ready handshake. The block sits between the job distributor (writer side of the interface) and the hashing core, and tags each block with a job ID so downstream logic can discard results from superseded jobs.

---
 rtl/core_job_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/core_job_sequencer.sv
// core_job_sequencer: latches a mining job and streams padded second-chunk
// SHA-256 message blocks, one per nonce, over a valid/ready handshake.
module core_job_sequencer #(
    parameter logic [31:0] NONCE_OFFSET = 32'd0,
    parameter logic [31:0] NONCE_STEP   = 32'd1,
    parameter int          JOB_ID_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic                newblock,
    input  logic [255:0]        hashstate,
    input  logic [31:0]         w1,
    input  logic [31:0]         w2,
    input  logic [31:0]         w3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [255:0]        out_midstate,
    output logic [511:0]        out_block,
    output logic [31:0]         out_nonce,
    output logic [JOB_ID_W-1:0] out_job,
    output logic                busy,
    output logic                exhausted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [255:0]        hs_q, hs_d;
    logic [31:0]         w1_q, w1_d;
    logic [31:0]         w2_q, w2_d;
    logic [31:0]         w3_q, w3_d;
    logic [31:0]         nonce_q, nonce_d;
    logic [JOB_ID_W-1:0] job_q, job_d;

    logic                capture;
    logic                handshake;
    logic [32:0]         nonce_sum;

    assign capture   = valid && newblock;
    assign handshake = (state_q == RUN) && out_ready;
    // 33-bit add: the carry-out marks the end of this core's nonce space.
    assign nonce_sum = {1'b0, nonce_q} + {1'b0, NONCE_STEP};

    // Next-state logic: a new job always wins over a concurrent handshake.
    always_comb begin
        state_d = state_q;
        hs_d    = hs_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        nonce_d = nonce_q;
        job_d   = job_q;
        if (capture) begin
            state_d = RUN;
            hs_d    = hashstate;
            w1_d    = w1;
            w2_d    = w2;
            w3_d    = w3;
            nonce_d = NONCE_OFFSET;
            job_d   = job_q + {{(JOB_ID_W-1){1'b0}}, 1'b1};
        end else if (handshake) begin
            if (nonce_sum[32]) begin
                state_d = DONE;
            end else begin
                nonce_d = nonce_sum[31:0];
            end
        end
    end

    // State and job registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hs_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            nonce_q <= '0;
            job_q   <= '0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            nonce_q <= nonce_d;
            job_q   <= job_d;
        end
    end

    // All outputs decode straight from registers, so they hold under backpressure.
    assign out_valid    = (state_q == RUN);
    assign busy         = (state_q == RUN);
    assign exhausted    = (state_q == DONE);
    assign out_midstate = hs_q;
    assign out_nonce    = nonce_q;
    assign out_job      = job_q;
    // W0..W3 = w1,w2,w3,nonce; W4 = pad bit; W5..W14 = 0; W15 = 640-bit length.
    assign out_block    = {w1_q, w2_q, w3_q, nonce_q, 32'h8000_0000,
                           320'd0, 32'h0000_0280};

endmodule
